// File: rtl/bada_nbc_sched.sv
// Non-zero compaction sequencer: drops pairs with a zero operand and issues the survivors lowest index first.
// Statistics counters are built only when BADA_SCHED_STATS_EN is defined.
module bada_nbc_sched #(
  parameter int OP_WIDTH   = 4,
  parameter int N_INPUT    = 4,
`ifdef BADA_SCHED_STATS_EN
  parameter int STAT_WIDTH = 16,
`endif
  localparam int IDX_WIDTH = $clog2(N_INPUT)
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N_INPUT*OP_WIDTH-1:0] in_op_a,
  input  logic [N_INPUT*OP_WIDTH-1:0] in_op_b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OP_WIDTH-1:0]         out_a,
  output logic [OP_WIDTH-1:0]         out_b,
  output logic [IDX_WIDTH-1:0]        out_idx,
  output logic                        out_last,
  output logic                        out_zero
`ifdef BADA_SCHED_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0]       stat_issued,
  output logic [STAT_WIDTH-1:0]       stat_skipped
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_EMPTY} state_t;

  state_t                r_state, w_state_nxt;
  logic [N_INPUT-1:0]    r_mask, w_mask_nxt, w_m, w_low;
  logic [OP_WIDTH-1:0]   r_a [N_INPUT];
  logic [OP_WIDTH-1:0]   r_b [N_INPUT];
  logic [IDX_WIDTH-1:0]  w_idx;
  logic                  w_out_hs, w_accept;

  always_comb begin
    w_m = '0;
    for (int i = 0; i < N_INPUT; i++) begin
      w_m[i] = (in_op_a[OP_WIDTH*i +: OP_WIDTH] != '0) && (in_op_b[OP_WIDTH*i +: OP_WIDTH] != '0);
    end
  end

  // Lowest pending bit isolated arithmetically; the encoder below just names its position.
  assign w_low = r_mask & (~r_mask + N_INPUT'(1));

  always_comb begin
    w_idx = '0;
    for (int i = N_INPUT - 1; i >= 0; i--) begin
      if (r_mask[i]) w_idx = i[IDX_WIDTH-1:0];
    end
  end

  assign out_valid = (r_state != S_IDLE);
  assign out_zero  = (r_state == S_EMPTY);
  assign out_last  = (r_state == S_EMPTY) ||
                     ((r_state == S_ISSUE) && ((r_mask & (r_mask - N_INPUT'(1))) == '0));
  assign out_a     = (r_state == S_ISSUE) ? r_a[w_idx] : '0;
  assign out_b     = (r_state == S_ISSUE) ? r_b[w_idx] : '0;
  assign out_idx   = (r_state == S_ISSUE) ? w_idx : '0;
  assign w_out_hs  = out_valid && out_ready;
  assign in_ready  = (r_state == S_IDLE) || (w_out_hs && out_last);
  assign w_accept  = in_valid && in_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    case (r_state)
      S_ISSUE: begin
        if (w_out_hs) begin
          w_mask_nxt = r_mask & ~w_low;
          if (out_last) w_state_nxt = S_IDLE;
        end
      end
      S_EMPTY: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = r_state;
      end
    endcase
    // A new vector overrides the closing beat so back-to-back vectors see no bubble.
    if (w_accept) begin
      w_mask_nxt  = w_m;
      w_state_nxt = (w_m != '0) ? S_ISSUE : S_EMPTY;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_mask  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_INPUT; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
      end
    end else if (w_accept) begin
      for (int i = 0; i < N_INPUT; i++) begin
        r_a[i] <= in_op_a[OP_WIDTH*i +: OP_WIDTH];
        r_b[i] <= in_op_b[OP_WIDTH*i +: OP_WIDTH];
      end
    end
  end

`ifdef BADA_SCHED_STATS_EN
  logic [STAT_WIDTH-1:0] r_stat_issued, r_stat_skipped;
  logic [STAT_WIDTH:0]   w_skip_cnt, w_skip_sum;

  always_comb begin
    w_skip_cnt = '0;
    for (int i = 0; i < N_INPUT; i++) begin
      if (!w_m[i]) w_skip_cnt = w_skip_cnt + (STAT_WIDTH+1)'(1);
    end
  end

  assign w_skip_sum = {1'b0, r_stat_skipped} + w_skip_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_issued  <= '0;
      r_stat_skipped <= '0;
    end else begin
      if (w_out_hs && (r_state == S_ISSUE) && (r_stat_issued != '1)) begin
        r_stat_issued <= r_stat_issued + STAT_WIDTH'(1);
      end
      if (w_accept) begin
        r_stat_skipped <= w_skip_sum[STAT_WIDTH] ? '1 : w_skip_sum[STAT_WIDTH-1:0];
      end
    end
  end

  assign stat_issued  = r_stat_issued;
  assign stat_skipped = r_stat_skipped;
`endif

endmodule

// File: tb/tb_bada_nbc_sched.sv
// Randomised bench for bada_nbc_sched: a queue of expected beats is built from each accepted vector.
module tb_bada_nbc_sched;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_op_a, in_op_b;
  logic        out_valid, out_ready;
  logic [3:0]  out_a, out_b;
  logic [1:0]  out_idx;
  logic        out_last, out_zero;
  logic [15:0] stat_issued, stat_skipped;

  int checks = 0;
  int errors = 0;

  // Expected beat = {a, b, idx, last, zero}
  logic [11:0] exp_q [$];
  int          m_issued, m_skipped;
  logic        stall_prev;
  logic [9:0]  held;

  always #5 clock = ~clock;

  bada_nbc_sched dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op_a     (in_op_a),
    .in_op_b     (in_op_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_idx     (out_idx),
    .out_last    (out_last),
    .out_zero    (out_zero)
`ifdef BADA_SCHED_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_skipped(stat_skipped)
`endif
  );

`ifndef BADA_SCHED_STATS_EN
  assign stat_issued  = '0;
  assign stat_skipped = '0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] pk(input logic [3:0] e3, input logic [3:0] e2,
                                     input logic [3:0] e1, input logic [3:0] e0);
    return {e3, e2, e1, e0};
  endfunction

  // Expand an accepted vector into its beat list from the compaction rule.
  task automatic model_accept(input logic [15:0] a, input logic [15:0] b);
    logic [3:0] ea, eb;
    int surv [$];
    for (int i = 0; i < 4; i++) begin
      ea = a[4*i +: 4];
      eb = b[4*i +: 4];
      if (ea != 0 && eb != 0) surv.push_back(i);
    end
    m_skipped += 4 - surv.size();
    if (surv.size() == 0) begin
      exp_q.push_back({4'd0, 4'd0, 2'd0, 1'b1, 1'b1});
    end else begin
      for (int k = 0; k < surv.size(); k++) begin
        ea = a[4*surv[k] +: 4];
        eb = b[4*surv[k] +: 4];
        exp_q.push_back({ea, eb, 2'(surv[k]), (k == surv.size() - 1), 1'b0});
      end
    end
  endtask

  task automatic step(input logic iv, input logic [15:0] a, input logic [15:0] b, input logic ordy);
    logic exp_rdy;
    logic [11:0] exp_beat;
    @(negedge clock);
    in_valid  = iv;
    in_op_a   = a;
    in_op_b   = b;
    out_ready = ordy;
    #1;
`ifdef BADA_SCHED_STATS_EN
    chk("stat_issued", 32'(stat_issued), 32'(m_issued));
    chk("stat_skipped", 32'(stat_skipped), 32'(m_skipped));
`endif
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (stall_prev) chk("stall_hold", 32'({out_a, out_b, out_idx}), 32'(held));
    exp_rdy = (exp_q.size() == 0) || (ordy && exp_q[0][1]);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (out_valid && out_ready && exp_q.size() != 0) begin
      exp_beat = exp_q.pop_front();
      chk("beat", 32'({out_a, out_b, out_idx, out_last, out_zero}), 32'(exp_beat));
      if (!exp_beat[0]) m_issued++;
    end
    if (in_valid && in_ready) model_accept(in_op_a, in_op_b);
    stall_prev = out_valid && !out_ready;
    held       = {out_a, out_b, out_idx};
  endtask

  task automatic idle_steps(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b0, 16'hffff, 16'hffff, ordy);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_outs", 32'({out_a, out_b, out_idx, out_last, out_zero}), 32'd0);
    exp_q.delete();
    m_issued   = 0;
    m_skipped  = 0;
    stall_prev = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [15:0] ra, rb;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_op_a   = '0;
    in_op_b   = '0;
    out_ready = 1'b0;
    #3;
    apply_reset();
    idle_steps(3, 1'b1);

    // Two survivors at idx 0 and 2
    step(1'b1, pk(0, 2, 0, 1), pk(0, 4, 0, 3), 1'b1);
    idle_steps(3, 1'b1);
`ifdef BADA_SCHED_STATS_EN
    chk("t2_issued", 32'(stat_issued), 32'd2);
    chk("t2_skipped", 32'(stat_skipped), 32'd2);
`endif

    // No survivors: a single dummy beat
    step(1'b1, 16'h0000, pk(5, 5, 5, 5), 1'b1);
    idle_steps(2, 1'b1);

    // Four survivors with a three-cycle stall on the first beat
    step(1'b1, pk(1, 2, 3, 4), pk(5, 6, 7, 8), 1'b0);
    idle_steps(3, 1'b0);
    idle_steps(5, 1'b1);

    // Back-to-back vectors with in_valid held high
    step(1'b1, pk(0, 2, 0, 1), pk(0, 4, 0, 3), 1'b1);
    step(1'b1, pk(9, 0, 7, 6), pk(1, 1, 0, 2), 1'b1);
    step(1'b1, pk(9, 0, 7, 6), pk(1, 1, 0, 2), 1'b1);
    idle_steps(4, 1'b1);

    // Reset in the middle of a three-beat vector
    step(1'b1, pk(0, 3, 2, 1), pk(0, 1, 1, 1), 1'b1);
    step(1'b0, 16'h0, 16'h0, 1'b1);
    @(posedge clock);
    #2;
    apply_reset();
    idle_steps(3, 1'b1);

    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 4; i++) begin
        ra[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        rb[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      end
      step(1'($urandom_range(0, 1)), ra, rb, ($urandom_range(0, 3) != 0));
    end
    idle_steps(6, 1'b1);
    chk("drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
